varint_decode_ctrl: RTL and testbench

VARINT_DECODE_CTRL -- requirements
Module: varint_decode_ctrl

---
 rtl/varint_pkg.sv | 16 +
 rtl/varint_accum.sv | 33 +++
 rtl/varint_decode_ctrl.sv | 107 ++++++++++
 tb/tb_varint_decode_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/varint_pkg.sv
// Shared types and constants for the LEB128-style varint decoder.
package varint_pkg;

  localparam int unsigned DefaultOutW     = 64;
  localparam int unsigned DefaultMaxBytes = 10;
  // Byte index width; covers MAX_BYTES up to 15.
  localparam int unsigned KW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StEmit,
    StError
  } state_e;

endpackage

// File: rtl/varint_accum.sv
// Varint accumulator: ORs each 7-bit payload group into place and counts bytes.
module varint_accum
  import varint_pkg::*;
#(
  parameter int unsigned OUT_W = DefaultOutW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [6:0]       data,
  output logic [OUT_W-1:0] acc,
  output logic [KW-1:0]    k
);

  logic [7:0]       shamt;
  logic [OUT_W-1:0] shifted;

  assign shamt = 8'(k) * 8'd7;
  // Groups landing beyond OUT_W fall off the top of the shift.
  assign shifted = OUT_W'(data) << shamt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
      k   <= '0;
    end else if (load) begin
      acc <= acc | shifted;
      k   <= k + KW'(1);
    end
  end

endmodule

// File: rtl/varint_decode_ctrl.sv
// Varint decode controller: pulls bytes from a show-ahead FIFO, assembles one
// value per varint and pushes it to the output FIFO.
module varint_decode_ctrl
  import varint_pkg::*;
#(
  parameter int unsigned OUT_W     = DefaultOutW,
  parameter int unsigned MAX_BYTES = DefaultMaxBytes
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clr,
  input  logic             varint_in_fifo_empty,
  input  logic [7:0]       varint_in_fifo_data,
  output logic             varint_in_fifo_pop,
  output logic             varint_in_index_pop,
  input  logic             varint_out_fifo_full,
  output logic [OUT_W-1:0] varint_out_fifo_data,
  output logic             varint_out_fifo_push,
  output logic             varint_out_index_push,
  output logic             varint_out_fifo_clr,
  output logic             varint_out_index_clr,
  output logic             busy,
  output logic             err_overlong,
  output logic [15:0]      decoded_count
);

  localparam logic [KW-1:0] LastK = KW'(MAX_BYTES - 1);

  state_e           state_q;
  logic             err_q;
  logic [15:0]      count_q;
  logic [OUT_W-1:0] hold_q;
  logic [OUT_W-1:0] acc;
  logic [KW-1:0]    k;
  logic             active, pop, push, start, terminate, overlong;

  // Reset beats clr, and clr suppresses every handshake in its cycle.
  assign active    = !reset && !clr;
  assign pop       = active && (state_q == StAccum) && !varint_in_fifo_empty;
  assign push      = active && (state_q == StEmit) && !varint_out_fifo_full;
  assign start     = active && (state_q == StIdle) && enable && !varint_in_fifo_empty;
  assign terminate = pop && !varint_in_fifo_data[7];
  assign overlong  = pop && varint_in_fifo_data[7] && (k == LastK);

  varint_accum #(
    .OUT_W(OUT_W)
  ) u_accum (
    .clk  (clk),
    .reset(reset),
    .clear(clr || start),
    .load (pop),
    .data (varint_in_fifo_data[6:0]),
    .acc  (acc),
    .k    (k)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      if (state_q == StEmit) hold_q <= acc;
      count_q <= count_q;
      if (clr) begin
        state_q <= StIdle;
        err_q   <= 1'b0;
        count_q <= '0;
      end else begin
        case (state_q)
          StIdle: if (start) state_q <= StAccum;
          StAccum: begin
            if (terminate) begin
              state_q <= StEmit;
            end else if (overlong) begin
              err_q   <= 1'b1;
              state_q <= StError;
            end
          end
          StEmit: begin
            if (push) begin
              count_q <= count_q + 16'd1;
              state_q <= StIdle;
            end
          end
          StError: state_q <= StError;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign varint_in_fifo_pop    = pop;
  assign varint_in_index_pop   = terminate;
  assign varint_out_fifo_push  = push;
  assign varint_out_index_push = push;
  assign varint_out_fifo_clr   = !reset && clr;
  assign varint_out_index_clr  = !reset && clr;
  assign busy                  = !reset && (state_q != StIdle);
  assign err_overlong          = err_q;
  assign decoded_count         = count_q;
  // Live accumulator while emitting; last emitted value otherwise.
  assign varint_out_fifo_data  = (state_q == StEmit) ? acc : hold_q;

endmodule

// File: tb/tb_varint_decode_ctrl.sv
// Scoreboard bench for varint_decode_ctrl: directed cases plus randomized varint streams.
module tb_varint_decode_ctrl;

  localparam int unsigned OUT_W     = 64;
  localparam int unsigned MAX_BYTES = 10;

  typedef logic [7:0] bq_t[$];

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             clr = 1'b0;
  logic             varint_in_fifo_empty = 1'b1;
  logic [7:0]       varint_in_fifo_data = 8'h00;
  logic             varint_out_fifo_full = 1'b0;
  logic             varint_in_fifo_pop, varint_in_index_pop;
  logic [OUT_W-1:0] varint_out_fifo_data;
  logic             varint_out_fifo_push, varint_out_index_push;
  logic             varint_out_fifo_clr, varint_out_index_clr;
  logic             busy, err_overlong;
  logic [15:0]      decoded_count;

  varint_decode_ctrl #(
    .OUT_W    (OUT_W),
    .MAX_BYTES(MAX_BYTES)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .clr                  (clr),
    .varint_in_fifo_empty (varint_in_fifo_empty),
    .varint_in_fifo_data  (varint_in_fifo_data),
    .varint_in_fifo_pop   (varint_in_fifo_pop),
    .varint_in_index_pop  (varint_in_index_pop),
    .varint_out_fifo_full (varint_out_fifo_full),
    .varint_out_fifo_data (varint_out_fifo_data),
    .varint_out_fifo_push (varint_out_fifo_push),
    .varint_out_index_push(varint_out_index_push),
    .varint_out_fifo_clr  (varint_out_fifo_clr),
    .varint_out_index_clr (varint_out_index_clr),
    .busy                 (busy),
    .err_overlong         (err_overlong),
    .decoded_count        (decoded_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  in_bytes[$];
  logic [63:0] exp_q[$];
  int          pop_cycs[$];
  bit          rnd_mode = 1'b0;
  bit          full_force = 1'b0;
  int          n_pop = 0, n_ipop = 0, n_push = 0, n_fclr = 0, n_iclr = 0;
  int          last_ipop_cyc = 0, push_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: little-endian 7-bit groups, anything past bit 63 dropped.
  function automatic logic [63:0] model(input bq_t bs);
    logic [63:0] v = '0;
    foreach (bs[i]) if (7 * i < 64) v |= 64'(bs[i][6:0]) << (7 * i);
    return v;
  endfunction

  task automatic send(input bq_t bs, input bit expect_push);
    foreach (bs[i]) in_bytes.push_back(bs[i]);
    if (expect_push) exp_q.push_back(model(bs));
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_pushes(input int n, input int budget, input string name);
    int t = 0;
    while (n_push < n && t < budget) begin
      tick();
      t++;
    end
    chk(name, 64'(n_push >= n), 64'd1);
    tick();
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #2;
  endtask

  // Input FIFO model and output-side back-pressure.
  always @(negedge clk) begin
    varint_in_fifo_empty = (in_bytes.size() == 0) || (rnd_mode && ($urandom_range(99) < 30));
    varint_in_fifo_data  = (in_bytes.size() != 0) ? in_bytes[0] : 8'h00;
    varint_out_fifo_full = full_force || (rnd_mode && ($urandom_range(99) < 30));
    enable               = !rnd_mode || ($urandom_range(99) < 70);
    #1;
    if (varint_in_fifo_pop) begin
      n_pop++;
      pop_cycs.push_back(cyc);
      chk("pop_while_empty", 64'(varint_in_fifo_empty), 64'd0);
      if (in_bytes.size() != 0) void'(in_bytes.pop_front());
    end
    if (varint_in_index_pop) begin
      n_ipop++;
      last_ipop_cyc = cyc;
    end
  end

  // Monitor: compares every push against the scoreboard queue.
  always @(negedge clk) begin
    #1;
    if (varint_out_fifo_clr) n_fclr++;
    if (varint_out_index_clr) n_iclr++;
    if (clr) chk("clr_blocks_handshake", {62'd0, varint_in_fifo_pop, varint_out_fifo_push}, 64'd0);
    if (varint_out_fifo_push || varint_out_index_push) begin
      chk("push_pair", {62'd0, varint_out_fifo_push, varint_out_index_push}, 64'd3);
      chk("push_while_full", 64'(varint_out_fifo_full), 64'd0);
      n_push++;
      push_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got %0h expected no push", varint_out_fifo_data);
      end else begin
        chk("push_data", varint_out_fifo_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bq_t         b;
    int          t, p0, ip0, fc0, ic0, np0;
    logic [15:0] cnt0;

    // Reset behaviour, including clr held during reset.
    tick();
    tick();
    clr = 1'b1;
    tick();
    chk("rst_pop", 64'(varint_in_fifo_pop), 64'd0);
    chk("rst_push", 64'(varint_out_fifo_push), 64'd0);
    chk("rst_fifo_clr", 64'(varint_out_fifo_clr), 64'd0);
    chk("rst_index_clr", 64'(varint_out_index_clr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    clr   = 1'b0;
    reset = 1'b0;
    #2;
    chk("rst_err", 64'(err_overlong), 64'd0);
    chk("rst_count", 64'(decoded_count), 64'd0);
    chk("rst_data", varint_out_fifo_data, 64'd0);

    // Single byte 0x05.
    pop_cycs.delete();
    b.delete();
    b.push_back(8'h05);
    send(b, 1'b1);
    wait_pushes(1, 20, "t05_push_seen");
    chk("t05_pops", 64'(n_pop), 64'd1);
    chk("t05_ipop_same_cycle", 64'(last_ipop_cyc), 64'(pop_cycs[0]));
    chk("t05_latency", 64'(push_cyc - pop_cycs[0]), 64'd1);
    chk("t05_count", 64'(decoded_count), 64'd1);

    // 0xAC 0x02 -> 300.
    pop_cycs.delete();
    b.delete();
    b.push_back(8'hAC);
    b.push_back(8'h02);
    send(b, 1'b1);
    wait_pushes(2, 20, "t300_push_seen");
    chk("t300_latency", 64'(push_cyc - pop_cycs[0]), 64'd2);
    chk("t300_after_term", 64'(push_cyc - last_ipop_cyc), 64'd1);
    chk("t300_count", 64'(decoded_count), 64'd2);

    // 0x96 0x01 with the output FIFO full for five cycles.
    full_force = 1'b1;
    b.delete();
    b.push_back(8'h96);
    b.push_back(8'h01);
    ip0 = n_ipop;
    send(b, 1'b1);
    t = 0;
    while (n_ipop == ip0 && t < 20) begin
      tick();
      t++;
    end
    chk("t150_term_seen", 64'(n_ipop - ip0), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t150_hold_nopush", 64'(varint_out_fifo_push), 64'd0);
      chk("t150_hold_data", varint_out_fifo_data, 64'd150);
      chk("t150_hold_busy", 64'(busy), 64'd1);
    end
    full_force = 1'b0;
    wait_pushes(3, 10, "t150_push_seen");
    tick();
    chk("t150_single_push", 64'(n_push), 64'd3);

    // Ten continuation bytes: overlong, then clr.
    p0 = n_pop;
    np0 = n_push;
    b.delete();
    for (int i = 0; i < 10; i++) b.push_back(8'h80);
    send(b, 1'b0);
    b.delete();
    b.push_back(8'h01);
    send(b, 1'b1);
    t = 0;
    while (!err_overlong && t < 40) begin
      tick();
      t++;
    end
    chk("ovl_err", 64'(err_overlong), 64'd1);
    tick();
    tick();
    tick();
    chk("ovl_pops", 64'(n_pop - p0), 64'd10);
    chk("ovl_no_pop_in_error", 64'(in_bytes.size()), 64'd1);
    chk("ovl_no_push", 64'(n_push - np0), 64'd0);
    chk("ovl_busy", 64'(busy), 64'd1);
    fc0 = n_fclr;
    pulse_clr();
    chk("ovl_clr_err", 64'(err_overlong), 64'd0);
    chk("ovl_clr_busy", 64'(busy), 64'd0);
    chk("ovl_clr_count", 64'(decoded_count), 64'd0);
    chk("ovl_clr_pulse", 64'(n_fclr - fc0), 64'd1);
    wait_pushes(np0 + 1, 20, "ovl_next_push_seen");
    chk("ovl_next_count", 64'(decoded_count), 64'd1);

    // Partial varint stalled on an empty FIFO, then clr.
    p0 = n_pop;
    b.delete();
    b.push_back(8'hFF);
    send(b, 1'b0);
    t = 0;
    while (n_pop == p0 && t < 20) begin
      tick();
      t++;
    end
    tick();
    tick();
    tick();
    chk("stall_pops", 64'(n_pop - p0), 64'd1);
    chk("stall_busy", 64'(busy), 64'd1);
    fc0 = n_fclr;
    ic0 = n_iclr;
    pulse_clr();
    chk("stall_fifo_clr", 64'(n_fclr - fc0), 64'd1);
    chk("stall_index_clr", 64'(n_iclr - ic0), 64'd1);
    chk("stall_clr_busy", 64'(busy), 64'd0);
    np0 = n_push;
    b.delete();
    b.push_back(8'h01);
    send(b, 1'b1);
    wait_pushes(np0 + 1, 20, "stall_next_push_seen");

    // Count wrap and the widest legal varint.
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    #2;
    chk("wrap_forced", 64'(decoded_count), 64'hFFFF);
    pop_cycs.delete();
    np0 = n_push;
    b.delete();
    for (int i = 0; i < 9; i++) b.push_back(8'hFF);
    b.push_back(8'h01);
    send(b, 1'b1);
    wait_pushes(np0 + 1, 40, "max_push_seen");
    chk("max_latency", 64'(push_cyc - pop_cycs[0]), 64'd10);
    chk("wrap_count", 64'(decoded_count), 64'd0);

    // Randomized streams under input stalls, output back-pressure and enable gaps.
    cnt0 = decoded_count;
    ip0 = n_ipop;
    for (int v = 0; v < 40; v++) begin
      int len;
      len = int'($urandom_range(MAX_BYTES, 1));
      b.delete();
      for (int i = 0; i < len - 1; i++) b.push_back(8'($urandom) | 8'h80);
      b.push_back(8'($urandom) & 8'h7F);
      send(b, 1'b1);
    end
    rnd_mode = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 6000) begin
      tick();
      t++;
    end
    rnd_mode = 1'b0;
    tick();
    tick();
    tick();
    chk("rnd_drained", 64'(exp_q.size()), 64'd0);
    chk("rnd_inputs_consumed", 64'(in_bytes.size()), 64'd0);
    chk("rnd_idle", 64'(busy), 64'd0);
    chk("rnd_count", 64'(decoded_count), 64'(cnt0 + 16'd40));
    chk("rnd_index_pops", 64'(n_ipop - ip0), 64'd40);
    chk("rnd_no_err", 64'(err_overlong), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
